// File: rtl/acorn128_pkg.sv
// ----------------------------------------------------------------------------
// acorn128_pkg : shared widths and scheduler FSM encoding for acorn128_job_sched
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package acorn128_pkg;

  localparam int KEY_W = 128;
  localparam int LEN_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CRST = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/acorn128_job_sched_if.sv
// ----------------------------------------------------------------------------
// acorn128_job_sched_if : host-side job request / result bus for the scheduler
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface acorn128_job_sched_if #(
  parameter int NREQ = 2
);
  import acorn128_pkg::*;

  logic [NREQ-1:0]       req_valid_in;
  logic [NREQ-1:0]       req_ready_out;
  logic [NREQ-1:0]       req_encrypt_in;
  logic [NREQ*KEY_W-1:0] req_key_in;
  logic [NREQ*KEY_W-1:0] req_iv_in;
  logic [NREQ*KEY_W-1:0] req_text_in;
  logic [NREQ*KEY_W-1:0] req_ad_in;
  logic [NREQ*LEN_W-1:0] req_len_in;
  logic [NREQ-1:0]       rsp_valid_out;
  logic [NREQ-1:0]       rsp_ready_in;
  logic [KEY_W-1:0]      rsp_text_out;
  logic [KEY_W-1:0]      rsp_tag_out;
  logic                  rsp_err_out;

  modport master (
    output req_valid_in, req_encrypt_in, req_key_in, req_iv_in,
           req_text_in, req_ad_in, req_len_in, rsp_ready_in,
    input  req_ready_out, rsp_valid_out, rsp_text_out, rsp_tag_out, rsp_err_out
  );

  modport slave (
    input  req_valid_in, req_encrypt_in, req_key_in, req_iv_in,
           req_text_in, req_ad_in, req_len_in, rsp_ready_in,
    output req_ready_out, rsp_valid_out, rsp_text_out, rsp_tag_out, rsp_err_out
  );

endinterface

`default_nettype wire

// File: rtl/acorn128_rr_arb.sv
// ----------------------------------------------------------------------------
// acorn128_rr_arb : one-hot round-robin grant, scanning upward from ptr_i
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module acorn128_rr_arb #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [PTR_W-1:0] nxt_ptr_o,
  output logic             any_o
);

  // Outer loop is the priority order; the first hit blocks all later ones.
  always_comb begin
    gnt_o     = '0;
    nxt_ptr_o = ptr_i;
    any_o     = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!any_o && req_i[i] && (i == ((int'(ptr_i) + off) % NREQ))) begin
          gnt_o[i]  = 1'b1;
          any_o     = 1'b1;
          nxt_ptr_o = PTR_W'((i + 1) % NREQ);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/acorn128_job_sched.sv
// ----------------------------------------------------------------------------
// acorn128_job_sched : round-robin job scheduler in front of one ACORN-128 core
// Optional watchdog on the core wait: define ACORN_TIMEOUT_EN.   Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module acorn128_job_sched
  import acorn128_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  acorn128_job_sched_if.slave bus,
  output logic             busy_out,
  output logic             core_rst_out,
  output logic             core_start_out,
  output logic             core_encrypt_out,
  output logic [KEY_W-1:0] core_key_out,
  output logic [KEY_W-1:0] core_iv_out,
  output logic [KEY_W-1:0] core_pt_out,
  output logic [KEY_W-1:0] core_ct_out,
  output logic [KEY_W-1:0] core_ad_out,
  output logic [LEN_W-1:0] core_len_out,
  input  logic [KEY_W-1:0] core_ct_in,
  input  logic [KEY_W-1:0] core_pt_in,
  input  logic [KEY_W-1:0] core_tag_in,
  input  logic             core_ready_in
);

  localparam int PTR_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("acorn128_job_sched: NREQ must be 2..8 and TIMEOUT_CYC >= 2");
  end

  sched_state_e     state_q, state_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic [NREQ-1:0]  arb_gnt, gnt_q;
  logic             arb_any;
  logic             wd_fire;

  logic             job_enc_q,  job_enc_d;
  logic [KEY_W-1:0] job_key_q,  job_key_d;
  logic [KEY_W-1:0] job_iv_q,   job_iv_d;
  logic [KEY_W-1:0] job_text_q, job_text_d;
  logic [KEY_W-1:0] job_ad_q,   job_ad_d;
  logic [LEN_W-1:0] job_len_q,  job_len_d;
  logic [KEY_W-1:0] rsp_text_q, rsp_tag_q;

  acorn128_rr_arb #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i     (bus.req_valid_in),
    .ptr_i     (rr_q),
    .gnt_o     (arb_gnt),
    .nxt_ptr_o (rr_d),
    .any_o     (arb_any)
  );

  always_comb begin
    job_enc_d  = 1'b0;
    job_key_d  = '0;
    job_iv_d   = '0;
    job_text_d = '0;
    job_ad_d   = '0;
    job_len_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        job_enc_d  = bus.req_encrypt_in[i];
        job_key_d  = bus.req_key_in[i*KEY_W +: KEY_W];
        job_iv_d   = bus.req_iv_in[i*KEY_W +: KEY_W];
        job_text_d = bus.req_text_in[i*KEY_W +: KEY_W];
        job_ad_d   = bus.req_ad_in[i*KEY_W +: KEY_W];
        job_len_d  = bus.req_len_in[i*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arb_any) state_d = ST_CRST;
      ST_CRST: state_d = ST_RUN;
      ST_RUN:  if (core_ready_in || wd_fire) state_d = ST_RESP;
      ST_RESP: if ((bus.rsp_ready_in & gnt_q) != '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      gnt_q      <= '0;
      job_enc_q  <= 1'b0;
      job_key_q  <= '0;
      job_iv_q   <= '0;
      job_text_q <= '0;
      job_ad_q   <= '0;
      job_len_q  <= '0;
      rsp_text_q <= '0;
      rsp_tag_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && arb_any) begin
        rr_q       <= rr_d;
        gnt_q      <= arb_gnt;
        job_enc_q  <= job_enc_d;
        job_key_q  <= job_key_d;
        job_iv_q   <= job_iv_d;
        job_text_q <= job_text_d;
        job_ad_q   <= job_ad_d;
        job_len_q  <= job_len_d;
      end
      if (state_q == ST_RUN && core_ready_in) begin
        rsp_text_q <= job_enc_q ? core_ct_in : core_pt_in;
        rsp_tag_q  <= core_tag_in;
      end else if (wd_fire) begin
        rsp_text_q <= '0;
        rsp_tag_q  <= '0;
      end
    end
  end

`ifdef ACORN_TIMEOUT_EN
  logic [31:0] wd_cnt_q;
  logic        rsp_err_q;

  // A ready in the same cycle as expiry takes precedence over the abort.
  assign wd_fire = (state_q == ST_RUN) && !core_ready_in &&
                   (wd_cnt_q == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || state_q != ST_RUN) wd_cnt_q <= '0;
    else                          wd_cnt_q <= wd_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)                                    rsp_err_q <= 1'b0;
    else if (state_q == ST_RUN && core_ready_in) rsp_err_q <= 1'b0;
    else if (wd_fire)                           rsp_err_q <= 1'b1;
  end

  assign bus.rsp_err_out = rsp_err_q;
`else
  assign wd_fire         = 1'b0;
  assign bus.rsp_err_out = 1'b0;
`endif

  // Reset masks the combinational outputs so the whole interface reads idle at once.
  assign bus.req_ready_out = (!rst && state_q == ST_IDLE) ? arb_gnt : '0;
  assign bus.rsp_valid_out = (!rst && state_q == ST_RESP) ? gnt_q : '0;
  assign bus.rsp_text_out  = rsp_text_q;
  assign bus.rsp_tag_out   = rsp_tag_q;
  assign busy_out          = !rst && (state_q != ST_IDLE);
  assign core_start_out    = !rst && (state_q == ST_RUN);
  assign core_rst_out      = rst || (state_q != ST_RUN);

  assign core_encrypt_out = job_enc_q;
  assign core_key_out     = job_key_q;
  assign core_iv_out      = job_iv_q;
  assign core_pt_out      = job_text_q;
  assign core_ct_out      = job_text_q;
  assign core_ad_out      = job_ad_q;
  assign core_len_out     = job_len_q;

endmodule

`default_nettype wire
